rf_writeback_unit: RTL

- Write-back stage on the producer side of the 4x8-bit register file write port; sole driver of its write address, write data and write enable.
- Merges ALU results (fixed timing, never stalled) and load results (variable timing, may be back-pressured) onto that single port.
- Keeps a per-register pending scoreboard that decode uses for RAW/WAW stalls.

---
 rtl/rf_writeback_unit_pkg.sv | 16 +
 rtl/rf_writeback_unit_if.sv | 58 +++++
 rtl/rf_wb_queue.sv | 59 +++++
 rtl/rf_writeback_unit.sv | 103 ++++++++++
 4 files changed

// File: rtl/rf_writeback_unit_pkg.sv
// Shared widths and types for the register-file write-back slice.
// Optional forwarding taps are enabled with RF_WB_BYPASS_EN.
package rf_writeback_unit_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 2;
   localparam int unsigned NREGS  = 2 ** ADDR_W;

   typedef logic [ADDR_W-1:0] reg_addr_t;

   typedef struct packed {
      reg_addr_t         rd;
      logic [DATA_W-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/rf_writeback_unit_if.sv
// Producer-side bundle of the write-back unit: result sources, issue, scoreboard, RF write port.
// With RF_WB_BYPASS_EN defined, the decode forwarding taps q_a/q_b and fwd_* are added.
interface rf_writeback_unit_if;
   import rf_writeback_unit_pkg::*;

   logic              alu_valid;
   reg_addr_t         alu_rd;
   logic [DATA_W-1:0] alu_data;

   logic              ld_valid;
   reg_addr_t         ld_rd;
   logic [DATA_W-1:0] ld_data;
   logic              ld_ready;

   logic              issue_valid;
   reg_addr_t         issue_rd;
   logic [NREGS-1:0]  pending;

   logic              wb_we;
   reg_addr_t         wb_rw;
   logic [DATA_W-1:0] wb_data;

`ifdef RF_WB_BYPASS_EN
   reg_addr_t         q_a;
   reg_addr_t         q_b;
   logic              fwd_a_hit;
   logic              fwd_b_hit;
   logic [DATA_W-1:0] fwd_a_data;
   logic [DATA_W-1:0] fwd_b_data;
`endif

   modport master (
      output alu_valid, alu_rd, alu_data,
      output ld_valid, ld_rd, ld_data,
      input  ld_ready,
      output issue_valid, issue_rd,
      input  pending,
`ifdef RF_WB_BYPASS_EN
      output q_a, q_b,
      input  fwd_a_hit, fwd_b_hit, fwd_a_data, fwd_b_data,
`endif
      input  wb_we, wb_rw, wb_data
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data,
      input  ld_valid, ld_rd, ld_data,
      output ld_ready,
      input  issue_valid, issue_rd,
      output pending,
`ifdef RF_WB_BYPASS_EN
      input  q_a, q_b,
      output fwd_a_hit, fwd_b_hit, fwd_a_data, fwd_b_data,
`endif
      output wb_we, wb_rw, wb_data
   );

endinterface

// File: rtl/rf_wb_queue.sv
// Synchronous FIFO of pending load results; DEPTH must be a power of two so pointers wrap naturally.
module rf_wb_queue
   import rf_writeback_unit_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    push,
   input  wb_req_t push_data,
   input  logic    pop,
   output logic    full,
   output logic    empty,
   output wb_req_t head
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   wb_req_t       mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push_ok && !pop_ok) begin
            count <= count + 1'b1;
         end else if (pop_ok && !push_ok) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/rf_writeback_unit.sv
// Write-back stage: merges ALU and queued load results onto the RF write port and tracks pending writes.
// Define RF_WB_BYPASS_EN to expose combinational forwarding of the value being committed.
module rf_writeback_unit
   import rf_writeback_unit_pkg::*;
#(
   parameter int unsigned LQ_DEPTH = 2
) (
   input logic               clk,
   input logic               rst,
   rf_writeback_unit_if.slave bus
);

   logic              q_full;
   logic              q_empty;
   logic              q_push;
   logic              q_pop;
   wb_req_t           q_head;
   wb_req_t           ld_req;

   logic              ld_acc;
   logic              ld_bypass;

   logic              wb_we_q;
   reg_addr_t         wb_rw_q;
   logic [DATA_W-1:0] wb_data_q;
   logic [NREGS-1:0]  pending_q;
   logic [NREGS-1:0]  pending_nxt;

   // ld_ready looks only at the registered fill level, keeping alu_valid off its path.
   assign bus.ld_ready = ~rst & ~q_full;
   assign ld_acc       = bus.ld_valid & ~rst & ~q_full;
   assign ld_bypass    = ld_acc & ~bus.alu_valid & q_empty;
   assign q_push       = ld_acc & ~ld_bypass;
   assign q_pop        = ~bus.alu_valid & ~q_empty;
   assign ld_req       = '{rd: bus.ld_rd, data: bus.ld_data};

   rf_wb_queue #(
      .DEPTH (LQ_DEPTH)
   ) u_queue (
      .clk       (clk),
      .rst       (rst),
      .push      (q_push),
      .push_data (ld_req),
      .pop       (q_pop),
      .full      (q_full),
      .empty     (q_empty),
      .head      (q_head)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_we_q   <= 1'b0;
         wb_rw_q   <= '0;
         wb_data_q <= '0;
      end else if (bus.alu_valid) begin
         wb_we_q   <= 1'b1;
         wb_rw_q   <= bus.alu_rd;
         wb_data_q <= bus.alu_data;
      end else if (!q_empty) begin
         wb_we_q   <= 1'b1;
         wb_rw_q   <= q_head.rd;
         wb_data_q <= q_head.data;
      end else if (ld_acc) begin
         wb_we_q   <= 1'b1;
         wb_rw_q   <= bus.ld_rd;
         wb_data_q <= bus.ld_data;
      end else begin
         wb_we_q   <= 1'b0;
      end
   end

   // Clear on commit, then set on issue so a same-edge reissue stays pending.
   always_comb begin
      pending_nxt = pending_q;
      if (wb_we_q) begin
         pending_nxt[wb_rw_q] = 1'b0;
      end
      if (bus.issue_valid) begin
         pending_nxt[bus.issue_rd] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_nxt;
      end
   end

   assign bus.wb_we   = wb_we_q;
   assign bus.wb_rw   = wb_rw_q;
   assign bus.wb_data = wb_data_q;
   assign bus.pending = pending_q;

`ifdef RF_WB_BYPASS_EN
   assign bus.fwd_a_hit  = wb_we_q && (wb_rw_q == bus.q_a);
   assign bus.fwd_b_hit  = wb_we_q && (wb_rw_q == bus.q_b);
   assign bus.fwd_a_data = wb_data_q;
   assign bus.fwd_b_data = wb_data_q;
`endif

endmodule
